// File: rtl/lcd_rx_monitor.sv
// Receive-side LCD stream monitor: recovers pixel coordinates, measures frame geometry, tracks lock.
// Optional per-frame additive pixel checksum is enabled by defining LCD_RX_CHECKSUM_EN.
module lcd_rx_monitor #(
    parameter int   H_ACTIVE    = 800,
    parameter int   V_ACTIVE    = 480,
    parameter logic SYNC_POL    = 1'b0,
    parameter int   LOCK_FRAMES = 2
) (
    input  logic        clk_in,
    input  logic        sys_rst,
    input  logic [23:0] rgb_in,
    input  logic        de_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [10:0] pix_x,
    output logic [10:0] pix_y,
    output logic [23:0] pix_data,
    output logic        pix_valid,
    output logic        frame_start,
    output logic        frame_done,
    output logic [10:0] meas_width,
    output logic [10:0] meas_height,
    output logic        geom_err,
    output logic        locked,
    output logic [31:0] frame_sum
);

    // state   | meaning
    // WAIT_VS | after reset; DE ignored until the first VSYNC assertion
    // WAIT_DE | frame boundary seen, waiting for the first active pixel
    // ACTIVE  | inside a frame, counting pixels and lines
    typedef enum logic [1:0] {
        WAIT_VS = 2'd0,
        WAIT_DE = 2'd1,
        ACTIVE  = 2'd2
    } state_t;

    localparam logic        VS_IDLE = ~SYNC_POL;
    localparam logic [11:0] H_EXP   = 12'(H_ACTIVE);
    localparam logic [10:0] V_EXP   = 11'(V_ACTIVE);
    localparam logic [3:0]  LF      = 4'(LOCK_FRAMES);
    localparam logic [11:0] X_SAT   = 12'h800;
    localparam logic [10:0] Y_SAT   = 11'h7FF;

    // x counter is one bit wider so an over-long line is distinguishable from a 2047-pixel line
    function automatic logic [10:0] sat11(input logic [11:0] v);
        return v[11] ? 11'h7FF : v[10:0];
    endfunction

    logic [23:0] rgb_s1_q, rgb_s1_d;
    logic        de_s1_q, de_s1_d;
    logic        hs_s1_q, hs_s1_d;
    logic        vs_s1_q, vs_s1_d;
    logic        de_p_q, de_p_d;
    logic        vs_p_q, vs_p_d;

    state_t      state_q, state_d;
    logic [11:0] x_cnt_q, x_cnt_d;
    logic [10:0] line_cnt_q, line_cnt_d;
    logic        line_bad_q, line_bad_d;
    logic [3:0]  good_cnt_q, good_cnt_d;

    logic [10:0] pix_x_q, pix_x_d;
    logic [10:0] pix_y_q, pix_y_d;
    logic [23:0] pix_data_q, pix_data_d;
    logic        pix_valid_q, pix_valid_d;
    logic        frame_start_q, frame_start_d;
    logic        frame_done_q, frame_done_d;
    logic [10:0] meas_width_q, meas_width_d;
    logic [10:0] meas_height_q, meas_height_d;
    logic        geom_err_q, geom_err_d;
    logic        locked_q, locked_d;

    logic        vs_edge;
    logic        de_fall;
    logic        start_pix;
    logic        take_pix;
    logic        frame_bad;
    logic [10:0] line_cnt_c;
    logic        line_bad_c;

    // HSYNC is captured for observability only; line boundaries come from DE
    logic        unused_hs;
    assign unused_hs = hs_s1_q;

    always_comb begin
        rgb_s1_d = rgb_in;
        de_s1_d  = de_in;
        hs_s1_d  = hsync_in;
        vs_s1_d  = vsync_in;
        de_p_d   = de_s1_q;
        vs_p_d   = vs_s1_q;
    end

    always_comb begin
        vs_edge       = (vs_s1_q == SYNC_POL) && (vs_p_q != SYNC_POL);
        de_fall       = de_p_q && !de_s1_q;
        start_pix     = 1'b0;
        take_pix      = 1'b0;
        frame_bad     = 1'b0;
        line_cnt_c    = line_cnt_q;
        line_bad_c    = line_bad_q;

        state_d       = state_q;
        x_cnt_d       = x_cnt_q;
        line_cnt_d    = line_cnt_q;
        line_bad_d    = line_bad_q;
        good_cnt_d    = good_cnt_q;
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        pix_data_d    = pix_data_q;
        pix_valid_d   = 1'b0;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        meas_width_d  = meas_width_q;
        meas_height_d = meas_height_q;
        geom_err_d    = geom_err_q;
        locked_d      = locked_q;

        case (state_q)
            WAIT_VS: begin
                if (vs_edge) state_d = WAIT_DE;
            end
            WAIT_DE: begin
                if (de_s1_q) start_pix = 1'b1;
            end
            ACTIVE: begin
                // a line ending on the VSYNC cycle still belongs to the closing frame
                if (de_fall) begin
                    meas_width_d = sat11(x_cnt_q);
                    line_bad_c   = line_bad_q | (x_cnt_q != H_EXP);
                    line_cnt_c   = (line_cnt_q == Y_SAT) ? line_cnt_q : line_cnt_q + 11'd1;
                    x_cnt_d      = 12'd0;
                end
                line_cnt_d = line_cnt_c;
                line_bad_d = line_bad_c;
                if (vs_edge) begin
                    frame_bad     = line_bad_c | (line_cnt_c != V_EXP);
                    frame_done_d  = 1'b1;
                    meas_height_d = line_cnt_c;
                    geom_err_d    = frame_bad;
                    if (frame_bad) begin
                        good_cnt_d = 4'd0;
                    end else if (good_cnt_q != LF) begin
                        good_cnt_d = good_cnt_q + 4'd1;
                    end
                    locked_d   = !frame_bad && (good_cnt_d == LF);
                    x_cnt_d    = 12'd0;
                    line_cnt_d = 11'd0;
                    line_bad_d = 1'b0;
                    state_d    = WAIT_DE;
                    if (de_s1_q) start_pix = 1'b1;
                end else if (de_s1_q) begin
                    take_pix = 1'b1;
                end
            end
            default: state_d = WAIT_VS;
        endcase

        if (start_pix) begin
            state_d       = ACTIVE;
            pix_valid_d   = 1'b1;
            frame_start_d = 1'b1;
            pix_x_d       = 11'd0;
            pix_y_d       = 11'd0;
            pix_data_d    = rgb_s1_q;
            x_cnt_d       = 12'd1;
            line_cnt_d    = 11'd0;
            line_bad_d    = 1'b0;
        end

        if (take_pix) begin
            pix_valid_d = 1'b1;
            pix_x_d     = sat11(x_cnt_q);
            pix_y_d     = line_cnt_q;
            pix_data_d  = rgb_s1_q;
            if (x_cnt_q != X_SAT) x_cnt_d = x_cnt_q + 12'd1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (sys_rst) begin
            rgb_s1_q      <= '0;
            de_s1_q       <= 1'b0;
            hs_s1_q       <= 1'b0;
            vs_s1_q       <= VS_IDLE;
            de_p_q        <= 1'b0;
            vs_p_q        <= VS_IDLE;
            state_q       <= WAIT_VS;
            x_cnt_q       <= '0;
            line_cnt_q    <= '0;
            line_bad_q    <= 1'b0;
            good_cnt_q    <= '0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            pix_data_q    <= '0;
            pix_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            meas_width_q  <= '0;
            meas_height_q <= '0;
            geom_err_q    <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            rgb_s1_q      <= rgb_s1_d;
            de_s1_q       <= de_s1_d;
            hs_s1_q       <= hs_s1_d;
            vs_s1_q       <= vs_s1_d;
            de_p_q        <= de_p_d;
            vs_p_q        <= vs_p_d;
            state_q       <= state_d;
            x_cnt_q       <= x_cnt_d;
            line_cnt_q    <= line_cnt_d;
            line_bad_q    <= line_bad_d;
            good_cnt_q    <= good_cnt_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pix_data_q    <= pix_data_d;
            pix_valid_q   <= pix_valid_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            meas_width_q  <= meas_width_d;
            meas_height_q <= meas_height_d;
            geom_err_q    <= geom_err_d;
            locked_q      <= locked_d;
        end
    end

`ifdef LCD_RX_CHECKSUM_EN
    logic [31:0] acc_q, acc_d;
    logic [31:0] frame_sum_q, frame_sum_d;

    // a pixel arriving on the closing cycle is the first pixel of the next frame
    always_comb begin
        acc_d       = acc_q;
        frame_sum_d = frame_sum_q;
        if (frame_done_d) begin
            frame_sum_d = acc_q;
            acc_d       = 32'd0;
        end
        if (pix_valid_d) acc_d = acc_d + {8'd0, rgb_s1_q};
    end

    always_ff @(posedge clk_in) begin
        if (sys_rst) begin
            acc_q       <= '0;
            frame_sum_q <= '0;
        end else begin
            acc_q       <= acc_d;
            frame_sum_q <= frame_sum_d;
        end
    end

    assign frame_sum = frame_sum_q;
`else
    assign frame_sum = 32'd0;
`endif

    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_data    = pix_data_q;
    assign pix_valid   = pix_valid_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign meas_width  = meas_width_q;
    assign meas_height = meas_height_q;
    assign geom_err    = geom_err_q;
    assign locked      = locked_q;

endmodule

// File: tb/tb_lcd_rx_monitor.sv
// Scoreboard bench for lcd_rx_monitor with an 8x4 geometry; pixel and frame expectations
// are queued by the driver and popped by a monitor whenever the DUT presents them.
module tb_lcd_rx_monitor;
    localparam int H = 8;
    localparam int V = 4;

`ifdef LCD_RX_CHECKSUM_EN
    localparam logic [31:0] SUM_MASK = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] SUM_MASK = 32'h0;
`endif

    logic        clk_in   = 1'b0;
    logic        sys_rst  = 1'b1;
    logic [23:0] rgb_in   = '0;
    logic        de_in    = 1'b0;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b1;
    logic [10:0] pix_x, pix_y, meas_width, meas_height;
    logic [23:0] pix_data;
    logic        pix_valid, frame_start, frame_done, geom_err, locked;
    logic [31:0] frame_sum;

    always #5 clk_in = ~clk_in;

    lcd_rx_monitor #(
        .H_ACTIVE(H), .V_ACTIVE(V), .SYNC_POL(1'b0), .LOCK_FRAMES(2)
    ) dut (
        .clk_in(clk_in), .sys_rst(sys_rst), .rgb_in(rgb_in), .de_in(de_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .pix_x(pix_x), .pix_y(pix_y),
        .pix_data(pix_data), .pix_valid(pix_valid), .frame_start(frame_start),
        .frame_done(frame_done), .meas_width(meas_width), .meas_height(meas_height),
        .geom_err(geom_err), .locked(locked), .frame_sum(frame_sum)
    );

    typedef struct {
        int          x;
        int          y;
        logic [23:0] data;
        logic        fs;
        int          cyc;
    } pix_t;

    typedef struct {
        int          w;
        int          h;
        logic        err;
        logic        lock;
        logic [31:0] sum;
        int          cyc;
    } frm_t;

    pix_t pix_q[$];
    frm_t frm_q[$];
    pix_t pe;
    frm_t fe;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   special_on = 1'b0;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push_frame(input int w, input int h, input bit err, input bit lock,
                              input logic [31:0] sum);
        frm_q.push_back('{w, h, err, lock, sum & SUM_MASK, cyc + 2});
    endtask

    task automatic drive_line(input int y, input int width, input int gap, input bit first,
                              input bit vs_start, input bit expect_pix);
        for (int c = 0; c < width; c++) begin
            de_in    = 1'b1;
            hsync_in = 1'b1;
            rgb_in   = (special_on && y == 2 && c == 5) ? 24'h123456 : 24'h000001;
            if (vs_start) vsync_in = (c < 2) ? 1'b0 : 1'b1;
            if (expect_pix)
                pix_q.push_back('{(c > 2047) ? 2047 : c, y, rgb_in, first && c == 0, cyc + 2});
            tick();
        end
        if (vs_start) vsync_in = 1'b1;
        de_in  = 1'b0;
        rgb_in = '0;
        for (int g = 0; g < gap; g++) begin
            hsync_in = (g != 1);
            tick();
        end
        hsync_in = 1'b1;
    endtask

    task automatic drive_frame(input int nlines, input int last_w, input int last_gap,
                               input bit vs_first);
        for (int l = 0; l < nlines; l++)
            drive_line(l, (l == nlines - 1) ? last_w : H, (l == nlines - 1) ? last_gap : 3,
                       l == 0, vs_first && l == 0, 1'b1);
    endtask

    task automatic drive_vs(input bit exp_done, input int w, input int h, input bit err,
                            input bit lock, input logic [31:0] sum);
        de_in    = 1'b0;
        vsync_in = 1'b0;
        if (exp_done) push_frame(w, h, err, lock, sum);
        tick();
        tick();
        vsync_in = 1'b1;
        repeat (3) tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".pix_x"}, pix_x, 0);
        chk({tag, ".pix_y"}, pix_y, 0);
        chk({tag, ".pix_data"}, pix_data, 0);
        chk({tag, ".pix_valid"}, pix_valid, 0);
        chk({tag, ".frame_start"}, frame_start, 0);
        chk({tag, ".frame_done"}, frame_done, 0);
        chk({tag, ".meas_width"}, meas_width, 0);
        chk({tag, ".meas_height"}, meas_height, 0);
        chk({tag, ".geom_err"}, geom_err, 0);
        chk({tag, ".locked"}, locked, 0);
        chk({tag, ".frame_sum"}, frame_sum, 0);
    endtask

    always @(negedge clk_in) begin
        if (!sys_rst) begin
            if (pix_valid) begin
                if (pix_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pix: pix_valid=1 at x=%0d y=%0d, expected none", pix_x, pix_y);
                end else begin
                    pe = pix_q.pop_front();
                    chk("pix_x", pix_x, pe.x);
                    chk("pix_y", pix_y, pe.y);
                    chk("pix_data", pix_data, pe.data);
                    chk("frame_start", frame_start, pe.fs);
                    chk("pix_latency", cyc, pe.cyc);
                end
            end else if (frame_start) begin
                n_checks++;
                n_fail++;
                $display("FAIL frame_start_gate: frame_start=1 with pix_valid=0, expected 0");
            end
            if (frame_done) begin
                if (frm_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_frame_done: frame_done=1, expected 0 (cycle %0d)", cyc);
                end else begin
                    fe = frm_q.pop_front();
                    chk("meas_width", meas_width, fe.w);
                    chk("meas_height", meas_height, fe.h);
                    chk("geom_err", geom_err, fe.err);
                    chk("locked", locked, fe.lock);
                    chk("frame_sum", frame_sum, fe.sum);
                    chk("frame_done_latency", cyc, fe.cyc);
                end
            end
        end
    end

    initial begin
        repeat (30000) @(posedge clk_in);
        $display("FAIL watchdog: cycle budget of 30000 exceeded, expected finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        chk_all_zero("reset");
        sys_rst = 1'b0;
        tick();

        // DE before any VSYNC is ignored; the first VSYNC only arms the monitor
        drive_line(0, 5, 3, 1'b0, 1'b0, 1'b0);
        drive_vs(1'b0, 0, 0, 1'b0, 1'b0, 0);

        drive_frame(4, 8, 3, 1'b0);                       // A
        drive_vs(1'b1, 8, 4, 1'b0, 1'b0, 32);
        special_on = 1'b1;
        drive_frame(4, 8, 3, 1'b0);                       // B: 0x123456 at (5,2)
        special_on = 1'b0;
        drive_vs(1'b1, 8, 4, 1'b0, 1'b1, 32'h0012_3475);
        drive_frame(4, 8, 3, 1'b0);                       // C
        drive_vs(1'b1, 8, 4, 1'b0, 1'b1, 32);
        drive_frame(4, 7, 3, 1'b0);                       // D: short last line
        drive_vs(1'b1, 7, 4, 1'b1, 1'b0, 31);
        drive_frame(4, 8, 3, 1'b0);                       // E
        drive_vs(1'b1, 8, 4, 1'b0, 1'b0, 32);
        drive_frame(4, 8, 3, 1'b0);                       // F
        drive_vs(1'b1, 8, 4, 1'b0, 1'b1, 32);
        drive_frame(5, 8, 3, 1'b0);                       // G: five lines
        drive_vs(1'b1, 8, 5, 1'b1, 1'b0, 40);
        drive_frame(1, 2100, 3, 1'b0);                    // H: over-long line
        drive_vs(1'b1, 2047, 1, 1'b1, 1'b0, 2100);
        drive_frame(4, 8, 0, 1'b0);                       // I: DE fall on VSYNC edge
        drive_vs(1'b1, 8, 4, 1'b0, 1'b0, 32);
        drive_frame(4, 8, 3, 1'b0);                       // J
        push_frame(8, 4, 1'b0, 1'b1, 32);
        drive_frame(4, 8, 3, 1'b1);                       // K: first pixel on VSYNC edge
        drive_vs(1'b1, 8, 4, 1'b0, 1'b1, 32);

        drive_line(0, 8, 3, 1'b1, 1'b0, 1'b1);            // L: reset mid-frame
        drive_line(1, 8, 3, 1'b0, 1'b0, 1'b1);
        chk("pix_queue_before_reset", pix_q.size(), 0);
        sys_rst = 1'b1;
        tick();
        chk_all_zero("midframe_reset");
        sys_rst = 1'b0;
        drive_line(2, 8, 3, 1'b0, 1'b0, 1'b0);
        drive_line(3, 8, 3, 1'b0, 1'b0, 1'b0);
        drive_vs(1'b0, 0, 0, 1'b0, 1'b0, 0);
        drive_frame(4, 8, 3, 1'b0);                       // M
        drive_vs(1'b1, 8, 4, 1'b0, 1'b0, 32);

        repeat (5) tick();
        chk("pix_queue_empty", pix_q.size(), 0);
        chk("frame_queue_empty", frm_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lcd_rx_monitor.md
Name: lcd_rx_monitor

Overview:
Receive-side counterpart of the LCD output path. It samples a parallel RGB/DE/HSYNC/VSYNC stream in the LCD pixel clock domain and recovers pixel coordinates and pixel data. It measures frame geometry, checks it against the expected resolution, and reports lock and errors. It is used as a loopback checker and capture front-end for the calculator UI frames.

Parameters:
H_ACTIVE, 800, expected active pixels per line
V_ACTIVE, 480, expected active lines per frame
SYNC_POL, 0, sync active level (0 = active-low HSYNC/VSYNC)
LOCK_FRAMES, 2, consecutive good frames required to assert locked (range 1..15)

Ports:
clk_in  input  1  LCD pixel clock; all inputs are synchronous to it
sys_rst  input  1  synchronous active-high reset
rgb_in  input  24  pixel data {R,G,B}
de_in  input  1  data enable
hsync_in  input  1  horizontal sync
vsync_in  input  1  vertical sync
pix_x  output  11  column of current valid pixel
pix_y  output  11  row of current valid pixel
pix_data  output  24  registered pixel value
pix_valid  output  1  pixel outputs valid this cycle
frame_start  output  1  1-cycle pulse with first valid pixel of a frame
frame_done  output  1  1-cycle pulse at frame evaluation
meas_width  output  11  DE-high length of last completed line
meas_height  output  11  line count of last evaluated frame
geom_err  output  1  last evaluated frame mismatched H_ACTIVE/V_ACTIVE
locked  output  1  geometry stable
frame_sum  output  32  additive pixel checksum of last frame (optional feature)

Behaviour:
- Reset: every output is 0; FSM goes to WAIT_VS; good-frame counter is 0.
- Stage 1 registers all inputs. Stage 2 drives the outputs. pix_valid, pix_data, pix_x and pix_y follow de_in with exactly 2 cycles of latency.
- vs_edge is defined as the stage-1 VSYNC transition into its active level (per SYNC_POL). HSYNC is used for no decisions other than being registered; line boundaries come from DE falling edges.
- FSM WAIT_VS: ignore DE. On vs_edge, go to WAIT_DE. No frame_done is issued here, so a partial frame after reset is never evaluated.
- FSM WAIT_DE: on the first DE-high, assert frame_start together with pix_valid, with pix_x=0 and pix_y=0. Go to ACTIVE.
- FSM ACTIVE:
  - pix_x increments on each DE-high cycle and returns to 0 on DE fall.
  - On DE fall: meas_width <= line length; line_cnt++; pix_y increments for the next line.
  - Any line length != H_ACTIVE sets a per-frame line_bad flag.
  - On vs_edge: frame_done pulses (stage-2 timing). meas_height <= line_cnt. geom_err <= line_bad | (line_cnt != V_ACTIVE). Counters and line_bad clear. Go to WAIT_DE.
- Saturation:
  - pix_x holds at 2047 if DE stays high longer, and that line counts as bad.
  - line_cnt and pix_y hold at 2047.
- Lock:
  - On each good frame, the good counter increments, saturating at LOCK_FRAMES. locked=1 when the counter equals LOCK_FRAMES.
  - Any bad frame clears the counter and locked in the same cycle frame_done pulses.
- Simultaneous events:
  - vs_edge in the same stage-1 cycle as DE-high: the frame closes first, then that pixel starts the new frame (frame_start asserts).
  - DE falling on the vs_edge cycle: the line is counted in the closing frame.
- Reset mid-frame: all state is discarded; behaviour resumes from WAIT_VS.

Optional Feature:
LCD_RX_CHECKSUM_EN:
- Defined: a 32-bit accumulator adds the zero-extended rgb value of every valid pixel, modulo 2^32. At frame_done, frame_sum <= accumulator, then the accumulator clears.
- Undefined: frame_sum is tied to 0 and no accumulator logic exists.

Test Plan:
- H_ACTIVE=8, V_ACTIVE=4: 3 frames of 4 lines × 8 DE cycles, with VSYNC low for 2 cycles between frames -> frame_done×3 after the first vs_edge, meas_width=8, meas_height=4, geom_err=0, locked=1 at the second evaluated frame.
- Single pixel rgb=0x123456 at line 2, column 5 -> 2 cycles later pix_valid=1, pix_x=5, pix_y=2, pix_data=0x123456.
- Locked stream, one line with 7 DE cycles -> at frame_done geom_err=1, locked=0, meas_width=7 for that line; next two good frames restore locked=1.
- Frame with 5 lines -> meas_height=5, geom_err=1; DE held high for 2100 cycles -> pix_x saturates at 2047 and geom_err=1.
- sys_rst pulsed mid-frame -> all outputs 0 next cycle; no frame_done until a full vs_edge-to-vs_edge frame completes.
- LCD_RX_CHECKSUM_EN, 8×4 frame of constant 0x000001 -> frame_sum=32; undefined -> frame_sum=0.
